// File: rtl/mod503_chunk_accumulator.sv
// Accumulates per-chunk weighted residues modulo MODULUS over a valid/ready stream and
// presents the operand's final residue, saturating term count and range-error flag.
module mod503_chunk_accumulator #(
    parameter int unsigned MODULUS = 503,
    parameter int unsigned WIDTH   = 9,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_in_data,
    input  logic             i_in_last,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out_residue,
    output logic [CNT_W-1:0] o_out_terms,
    output logic             o_out_range_err
);

    localparam logic [WIDTH-1:0] MOD_W   = WIDTH'(MODULUS);
    localparam logic [WIDTH:0]   MOD_S   = (WIDTH + 1)'(MODULUS);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [0:0] {
        StAccum,
        StDone
    } state_e;

    state_e           r_state;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_term_cnt;
    logic             r_range_err;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_residue;
    logic [CNT_W-1:0] r_out_terms;
    logic             r_out_range_err;

    logic             w_over;
    logic [WIDTH-1:0] w_d;
    logic [WIDTH:0]   w_sum;
    logic             w_wrap;
    logic [WIDTH-1:0] w_new_acc;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_accept;

    assign w_over    = i_in_data >= MOD_W;
    assign w_d       = w_over ? (i_in_data - MOD_W) : i_in_data;
    assign w_sum     = {1'b0, r_acc} + {1'b0, w_d};
    assign w_wrap    = w_sum >= MOD_S;
    // True result is below MODULUS, so the low WIDTH bits of the subtract are exact.
    assign w_new_acc = w_sum[WIDTH-1:0] - (w_wrap ? MOD_W : '0);
    assign w_cnt_inc = (r_term_cnt == CNT_MAX) ? r_term_cnt : (r_term_cnt + 1'b1);
    assign w_accept  = i_in_valid && r_in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= StAccum;
            r_acc           <= '0;
            r_term_cnt      <= '0;
            r_range_err     <= 1'b0;
            r_in_ready      <= 1'b0;
            r_out_valid     <= 1'b0;
            r_out_residue   <= '0;
            r_out_terms     <= '0;
            r_out_range_err <= 1'b0;
        end else begin
            unique case (r_state)
                StAccum: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        if (i_in_last) begin
                            r_out_residue   <= w_new_acc;
                            r_out_terms     <= w_cnt_inc;
                            r_out_range_err <= r_range_err | w_over;
                            r_out_valid     <= 1'b1;
                            r_in_ready      <= 1'b0;
                            r_acc           <= '0;
                            r_term_cnt      <= '0;
                            r_range_err     <= 1'b0;
                            r_state         <= StDone;
                        end else begin
                            r_acc       <= w_new_acc;
                            r_term_cnt  <= w_cnt_inc;
                            r_range_err <= r_range_err | w_over;
                        end
                    end
                end
                StDone: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= StAccum;
                    end
                end
                default: begin
                    r_state <= StAccum;
                end
            endcase
        end
    end

    assign o_in_ready      = r_in_ready;
    assign o_out_valid     = r_out_valid;
    assign o_out_residue   = r_out_residue;
    assign o_out_terms     = r_out_terms;
    assign o_out_range_err = r_out_range_err;

endmodule

// File: tb/tb_mod503_chunk_accumulator.sv
// Randomized self-checking bench: operands are reduced by a plain-arithmetic model and compared
// against the accumulator's result, with directed reset, back-pressure and saturation cases.
module tb_mod503_chunk_accumulator;

    localparam int MOD = 503;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_in_valid = 1'b0;
    logic       o_in_ready;
    logic [8:0] i_in_data = '0;
    logic       i_in_last = 1'b0;
    logic       o_out_valid;
    logic       i_out_ready = 1'b0;
    logic [8:0] o_out_residue;
    logic [7:0] o_out_terms;
    logic       o_out_range_err;

    int n_total = 0;
    int n_bad   = 0;

    mod503_chunk_accumulator dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_in_valid      (i_in_valid),
        .o_in_ready      (o_in_ready),
        .i_in_data       (i_in_data),
        .i_in_last       (i_in_last),
        .o_out_valid     (o_out_valid),
        .i_out_ready     (i_out_ready),
        .o_out_residue   (o_out_residue),
        .o_out_terms     (o_out_terms),
        .o_out_range_err (o_out_range_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: mod-MOD sum of normalised terms, saturating count, any-out-of-range flag.
    function automatic void model(input int terms[$], output int res, output int cnt,
                                  output int err);
        longint sum = 0;
        err = 0;
        foreach (terms[i]) begin
            sum += (terms[i] >= MOD) ? terms[i] - MOD : terms[i];
            if (terms[i] >= MOD) err = 1;
        end
        res = int'(sum % MOD);
        cnt = (terms.size() > 255) ? 255 : terms.size();
    endfunction

    // Called at a negedge; returns at the negedge right after the accepting posedge.
    task automatic send_term(input int data, input bit last, input int max_gap);
        int budget = 50;
        i_in_valid = 1'b1;
        i_in_data  = 9'(data);
        i_in_last  = last;
        while (!o_in_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) check_eq("ready_timeout", 0, 1);
        @(negedge clk);
        i_in_valid = 1'b0;
        i_in_last  = 1'b0;
        if (!last && max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
    endtask

    task automatic check_result(input string tag, input int terms[$]);
        int res, cnt, err;
        model(terms, res, cnt, err);
        check_eq({tag, "_valid"}, 32'(o_out_valid), 1);
        check_eq({tag, "_residue"}, 32'(o_out_residue), res);
        check_eq({tag, "_terms"}, 32'(o_out_terms), cnt);
        check_eq({tag, "_err"}, 32'(o_out_range_err), err);
        check_eq({tag, "_inrdy"}, 32'(o_in_ready), 0);
    endtask

    // Holds out_ready low for 'hold' cycles with stray in_valid pulses, then drains.
    task automatic drain(input string tag, input int terms[$], input int hold);
        int res, cnt, err;
        model(terms, res, cnt, err);
        for (int i = 0; i < hold; i++) begin
            i_in_valid = 1'($urandom_range(0, 1));
            i_in_data  = 9'($urandom_range(0, 511));
            i_in_last  = 1'b1;
            @(negedge clk);
            check_eq({tag, "_hold_valid"}, 32'(o_out_valid), 1);
            check_eq({tag, "_hold_residue"}, 32'(o_out_residue), res);
            check_eq({tag, "_hold_terms"}, 32'(o_out_terms), cnt);
            check_eq({tag, "_hold_inrdy"}, 32'(o_in_ready), 0);
        end
        i_in_valid  = 1'b0;
        i_in_last   = 1'b0;
        i_out_ready = 1'b1;
        @(negedge clk);
        i_out_ready = 1'b0;
        check_eq({tag, "_drain_valid"}, 32'(o_out_valid), 0);
        check_eq({tag, "_drain_inrdy"}, 32'(o_in_ready), 1);
    endtask

    task automatic run_operand(input string tag, input int terms[$], input int max_gap,
                               input int hold);
        foreach (terms[i]) send_term(terms[i], i == terms.size() - 1, max_gap);
        check_result(tag, terms);
        drain(tag, terms, hold);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_valid"}, 32'(o_out_valid), 0);
        check_eq({tag, "_inrdy"}, 32'(o_in_ready), 0);
        check_eq({tag, "_residue"}, 32'(o_out_residue), 0);
        check_eq({tag, "_terms"}, 32'(o_out_terms), 0);
        check_eq({tag, "_err"}, 32'(o_out_range_err), 0);
    endtask

    task automatic release_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq({tag, "_rdy_before_edge"}, 32'(o_in_ready), 0);
        @(negedge clk);
        check_eq({tag, "_rdy_after_edge"}, 32'(o_in_ready), 1);
    endtask

    initial begin
        int q[$];
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        release_reset("por");

        run_operand("t500_10", '{500, 10}, 0, 0);
        run_operand("t502_502", '{502, 502}, 1, 1);
        run_operand("single123", '{123}, 0, 0);
        run_operand("t511", '{511}, 0, 0);
        run_operand("after_err", '{5}, 0, 0);
        run_operand("backpress", '{77, 400, 300}, 0, 10);

        q = {};
        for (int i = 0; i < 300; i++) q.push_back(1);
        run_operand("sat300", q, 0, 0);

        // Reset mid-operand after 3 of 5 terms.
        send_term(200, 1'b0, 0);
        send_term(300, 1'b0, 0);
        send_term(400, 1'b0, 0);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("mid_rst");
        release_reset("mid_rst");
        run_operand("post_rst", '{100, 200}, 0, 0);

        // Reset while a result is pending.
        send_term(42, 1'b1, 0);
        check_result("pend", '{42});
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("done_rst");
        release_reset("done_rst");
        run_operand("post_done_rst", '{9, 8}, 0, 0);

        for (int n = 0; n < 40; n++) begin
            int len = $urandom_range(1, 8);
            q = {};
            for (int i = 0; i < len; i++)
                q.push_back(($urandom_range(0, 7) == 0) ? $urandom_range(503, 511)
                                                        : $urandom_range(0, 502));
            run_operand($sformatf("rnd%0d", n), q, 2, $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mod503_chunk_accumulator.md
Name: mod503_chunk_accumulator

Overview:
- Sequential stage directly downstream of the per-chunk residue LUTs in the mod-503 datapath.
- Each LUT maps a 6-bit operand chunk to its 9-bit weighted residue. This block accepts one residue per cycle over a valid/ready handshake and accumulates them modulo 503.
- After the term flagged last, it presents the final residue of the full-width operand, together with a term count and an error flag.

Parameters:
- MODULUS, 503, modulus for the reduction; must satisfy MODULUS < 2^WIDTH.
- WIDTH, 9, width of the residue and accumulator.
- CNT_W, 8, width of the term counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data/in_last valid.
- in_ready  output  1  block can accept a term this cycle.
- in_data  input  WIDTH  partial residue from a chunk LUT; nominally < MODULUS.
- in_last  input  1  marks the final term of an operand.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_residue  output  WIDTH  final residue, always < MODULUS.
- out_terms  output  CNT_W  number of terms accumulated, saturating.
- out_range_err  output  1  at least one in_data ≥ MODULUS during this operand.

Behaviour:
- Reset is asynchronous on rst_n low:
  - state = ACCUM, acc = 0, term_cnt = 0, range_err = 0.
  - out_valid = 0, out_residue = 0, out_terms = 0, out_range_err = 0.
  - in_ready is 0 while rst_n is low and goes to 1 on the first edge after release.
- States:
  - ACCUM: in_ready = 1, out_valid = 0.
  - DONE: in_ready = 0, out_valid = 1; outputs held stable.
- Term acceptance: a term is accepted on a rising edge with in_valid && in_ready.
- Input normalisation:
  - d = in_data − MODULUS if in_data ≥ MODULUS, else d = in_data. This is a single conditional subtract, so d < MODULUS for every WIDTH-bit input.
  - in_data ≥ MODULUS sets sticky range_err.
- Modular add:
  - s = acc + d, computed at WIDTH+1 bits.
  - new_acc = s − MODULUS if s ≥ MODULUS, else s.
  - Exactly one subtract is needed because both operands are < MODULUS.
- term_cnt increments per accepted term and saturates at 2^CNT_W − 1 without wrapping.
- Accepted term with in_last = 0: acc ← new_acc; stay in ACCUM.
- Accepted term with in_last = 1:
  - Next cycle: out_residue = new_acc, out_terms = term_cnt + 1 (saturated), out_range_err = range_err including the current term.
  - State → DONE. Latency from the last term to out_valid is 1 cycle.
  - acc, term_cnt and range_err clear to 0 internally.
- DONE:
  - out_valid && out_ready → state ACCUM next cycle; out_valid falls.
  - Output registers keep their last value but are don't-care while out_valid = 0.
  - in_valid is ignored in DONE (in_ready = 0), so no term is accepted in the handoff cycle. Throughput is at most one operand per N+1 cycles for N terms.
- in_valid = 0 in ACCUM: registers hold; no timeout.
- An operand with a single term (in_last on the first term) gives out_residue = d.
- Reset asserted mid-operand or during DONE discards the partial sum and pending result; no out_valid pulse.
- Only the terms in the current operand affect its result; no carry-over between operands.

Test Plan:
- Reset, then terms 500 (last = 0), 10 (last = 1) → one cycle later out_valid = 1, out_residue = 7, out_terms = 2, out_range_err = 0.
- Terms 502, 502 (last) → out_residue = 501; single term 123 with last → out_residue = 123, out_terms = 1.
- Term 511 (last) → out_residue = 8, out_range_err = 1; next operand 5 (last) → out_range_err = 0, out_residue = 5.
- Hold out_ready = 0 for 10 cycles after the result → out_valid and outputs stable, in_ready = 0, in_valid pulses ignored; then out_ready = 1 → out_valid = 0 and in_ready = 1 next cycle.
- 300 terms of value 1 with the last flag on the 300th → out_residue = 300, out_terms = 255 (saturated).
- Drop rst_n asynchronously after 3 of 5 terms → outputs 0 immediately. Then after release, terms 100, 200 (last) → out_residue = 300, out_terms = 2.
